// File: rtl/flag_unit_if.sv
// Handshake/bus bundle between the ALU/control side and flag_unit.
// master drives ALU flags and stack commands; slave returns flags and status.
interface flag_unit_if;
  logic       zero;
  logic       carry;
  logic       overflow;
  logic       sign;
  logic       we_flags;
  logic       push;
  logic       pop;
  logic [2:0] cond_sel;
  logic       clr_err;
  logic [3:0] flags;
  logic       cond_true;
  logic       full;
  logic       empty;
  logic       err;

  modport master (
    output zero, carry, overflow, sign,
    output we_flags, push, pop, cond_sel, clr_err,
    input  flags, cond_true, full, empty, err
  );

  modport slave (
    input  zero, carry, overflow, sign,
    input  we_flags, push, pop, cond_sel, clr_err,
    output flags, cond_true, full, empty, err
  );
endinterface

// File: rtl/flag_unit.sv
// Flag register, branch-condition decode and interrupt flag LIFO.
// Ports: clk, reset (async active-low), bus (flag_unit_if.slave).
// FLAG_STICKY_OV_EN: when defined, O accumulates across we_flags loads.
module flag_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  flag_unit_if.slave  bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [3:0]     flags_q;
  logic [3:0]     flags_d;
  logic [PTR_W:0] count_q;
  logic [PTR_W:0] count_d;
  logic           err_q;
  logic           err_d;
  logic [3:0]     stack [DEPTH];

  logic           full_s;
  logic           empty_s;
  logic           both;
  logic           do_push;
  logic           do_pop;
  logic           err_set;
  logic           ov_next;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == '0);

  // Simultaneous push and pop is treated as misuse and ignored.
  assign both    = bus.push & bus.pop;
  assign do_push = bus.push & ~bus.pop & ~full_s;
  assign do_pop  = bus.pop & ~bus.push & ~empty_s;
  assign err_set = both
                 | (bus.push & ~bus.pop & full_s)
                 | (bus.pop & ~bus.push & empty_s);

  assign wr_idx = PTR_W'(count_q);
  assign rd_idx = PTR_W'(count_q - 1'b1);

`ifdef FLAG_STICKY_OV_EN
  assign ov_next = bus.clr_err ? bus.overflow
                               : (flags_q[2] | bus.overflow);
`else
  assign ov_next = bus.overflow;
`endif

  always_comb begin
    flags_d = flags_q;
    if (do_pop)
      flags_d = stack[rd_idx];
    else if (bus.we_flags)
      flags_d = {bus.sign, ov_next, bus.carry, bus.zero};
  end

  always_comb begin
    count_d = count_q;
    if (do_push)
      count_d = count_q + 1'b1;
    else if (do_pop)
      count_d = count_q - 1'b1;
  end

  // A fresh error beats a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (err_set)
      err_d = 1'b1;
    else if (bus.clr_err)
      err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Stack storage needs no reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push)
      stack[wr_idx] <= flags_q;
  end

  always_comb begin
    bus.cond_true = 1'b0;
    unique case (bus.cond_sel)
      3'b000: bus.cond_true = 1'b1;
      3'b001: bus.cond_true = flags_q[0];
      3'b010: bus.cond_true = ~flags_q[0];
      3'b011: bus.cond_true = flags_q[1];
      3'b100: bus.cond_true = ~flags_q[1];
      3'b101: bus.cond_true = flags_q[2];
      3'b110: bus.cond_true = flags_q[3];
      3'b111: bus.cond_true = flags_q[3] ^ flags_q[2];
      default: bus.cond_true = 1'b0;
    endcase
  end

  assign bus.flags = flags_q;
  assign bus.full  = full_s;
  assign bus.empty = empty_s;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit.
// Vector table, hand sequences, then random stimulus against a queue model.
module tb_flag_unit;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  flag_unit_if bus ();

  flag_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       z, c, o, s, we, pu, po;
    logic [2:0] cs;
    logic       clr;
    logic [3:0] ef;
    logic       ec, efull, eempty, eerr;
  } vec_t;

  vec_t tbl [16];

  logic [3:0] m_flags;
  logic [3:0] m_stk [$];
  logic       m_err;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_of(input logic [3:0] f, input logic [2:0] cs);
    logic n, o, c, z;
    {n, o, c, z} = f;
    case (cs)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return o;
      3'd6: return n;
      default: return n != o;
    endcase
  endfunction

  task automatic drive(input logic z, c, o, s, we, pu, po,
                       input logic [2:0] cs, input logic clr);
    bus.zero = z; bus.carry = c; bus.overflow = o; bus.sign = s;
    bus.we_flags = we; bus.push = pu; bus.pop = po;
    bus.cond_sel = cs; bus.clr_err = clr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
  endtask

  task automatic model_step(input logic z, c, o, s, we, pu, po, clr);
    logic [3:0] nf;
    logic       eset;
    logic       ov;
    eset = 1'b0;
    nf   = m_flags;
`ifdef FLAG_STICKY_OV_EN
    ov = clr ? o : (m_flags[2] | o);
`else
    ov = o;
`endif
    if (we) nf = {s, ov, c, z};
    if (pu && po) eset = 1'b1;
    else if (pu) begin
      if (m_stk.size() == DEPTH) eset = 1'b1;
      else m_stk.push_back(m_flags);
    end else if (po) begin
      if (m_stk.size() == 0) eset = 1'b1;
      else nf = m_stk.pop_back();
    end
    m_flags = nf;
    if (eset) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", bus.flags, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    reset = 1'b1;

    //        z c o s we pu po cs clr | flags cond full empty err
    tbl[0]  = '{1,0,0,0,1,0,0,3'd1,0, 4'h1,1,0,1,0};
    tbl[1]  = '{0,0,0,1,1,0,0,3'd7,0, 4'h8,1,0,1,0};
    tbl[2]  = '{0,0,1,1,1,0,0,3'd7,0, 4'hC,0,0,1,0};
    tbl[3]  = '{0,1,0,0,1,0,0,3'd3,1, 4'h2,1,0,1,0};
    tbl[4]  = '{1,0,0,0,1,1,0,3'd4,0, 4'h1,1,0,0,0};
    tbl[5]  = '{0,0,0,0,0,0,1,3'd4,0, 4'h2,0,0,1,0};
    tbl[6]  = '{1,1,0,0,1,0,1,3'd1,0, 4'h3,1,0,1,1};
    tbl[7]  = '{0,0,0,0,0,0,0,3'd0,1, 4'h3,1,0,1,0};
    tbl[8]  = '{0,0,0,0,0,1,0,3'd5,0, 4'h3,0,0,0,0};
    tbl[9]  = '{0,0,0,0,0,1,0,3'd5,0, 4'h3,0,0,0,0};
    tbl[10] = '{0,0,0,0,0,1,0,3'd5,0, 4'h3,0,0,0,0};
    tbl[11] = '{0,0,0,0,0,1,0,3'd6,0, 4'h3,0,1,0,0};
    tbl[12] = '{0,0,0,0,0,1,0,3'd6,0, 4'h3,0,1,0,1};
    tbl[13] = '{0,0,0,0,0,1,1,3'd6,1, 4'h3,0,1,0,1};
    tbl[14] = '{0,0,0,0,0,0,0,3'd0,1, 4'h3,1,1,0,0};
    tbl[15] = '{0,0,0,0,0,0,1,3'd2,0, 4'h3,0,0,0,0};

    foreach (tbl[i]) begin
      drive(tbl[i].z, tbl[i].c, tbl[i].o, tbl[i].s, tbl[i].we,
            tbl[i].pu, tbl[i].po, tbl[i].cs, tbl[i].clr);
      @(posedge clk);
      #1;
      bus.we_flags = 0; bus.push = 0; bus.pop = 0; bus.clr_err = 0;
      chk($sformatf("v%0d_flags", i), bus.flags, tbl[i].ef);
      chk($sformatf("v%0d_cond", i), bus.cond_true, tbl[i].ec);
      chk($sformatf("v%0d_full", i), bus.full, tbl[i].efull);
      chk($sformatf("v%0d_empty", i), bus.empty, tbl[i].eempty);
      chk($sformatf("v%0d_err", i), bus.err, tbl[i].eerr);
    end

    // Asynchronous reset in the middle of a cycle with a partly filled stack.
    idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    drive(0, 1, 0, 1, 1, 1, 0, 3'd0, 0);
    @(posedge clk); #1;
    bus.we_flags = 0;
    @(posedge clk); #1;
    idle();
    chk("pre_rst_empty", bus.empty, 0);
    chk("pre_rst_flags", bus.flags, 4'hA);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_flags", bus.flags, 0);
    chk("async_empty", bus.empty, 1);
    chk("async_err", bus.err, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 3'd0, 0);
    @(posedge clk); #1;
    idle();
    chk("lost_pop_err", bus.err, 1);
    chk("lost_pop_flags", bus.flags, 0);

    // Overflow accumulation across two loads.
    drive(0, 0, 1, 0, 1, 0, 0, 3'd5, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 0, 3'd5, 0);
    @(posedge clk); #1;
    idle();
`ifdef FLAG_STICKY_OV_EN
    chk("sticky_o", bus.flags[2], 1);
`else
    chk("plain_o", bus.flags[2], 0);
`endif

    // Random stimulus against the queue model.
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_flags = 4'h0;
    m_stk.delete();
    m_err = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic z, c, o, s, we, pu, po, clr;
      logic [2:0] cs;
      z   = 1'($urandom);
      c   = 1'($urandom);
      o   = 1'($urandom);
      s   = 1'($urandom);
      we  = ($urandom_range(0, 99) < 50);
      pu  = ($urandom_range(0, 99) < 35);
      po  = ($urandom_range(0, 99) < 30);
      clr = ($urandom_range(0, 99) < 10);
      cs  = 3'($urandom);
      drive(z, c, o, s, we, pu, po, cs, clr);
      #1;
      chk("rnd_cond", bus.cond_true, cond_of(m_flags, cs));
      @(posedge clk);
      model_step(z, c, o, s, we, pu, po, clr);
      #1;
      chk("rnd_flags", bus.flags, m_flags);
      chk("rnd_full", bus.full, m_stk.size() == DEPTH);
      chk("rnd_empty", bus.empty, m_stk.size() == 0);
      chk("rnd_err", bus.err, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
